// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_if
// Brief    : Pipeline <-> hazard controller signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW, ResultSrcE0, PCSrcE;
  logic        dmem_req, dmem_ready;
  logic        StallF, StallD, StallE, StallM;
  logic        FlushD, FlushE, FlushW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        mem_err;
  logic [31:0] stall_cnt, flush_cnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, dmem_req, dmem_ready,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, dmem_req, dmem_ready,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE, mem_err, stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Stall/flush/forwarding control with boot flush, memory wait
//            timeout and sticky error freeze. Optional counters: HAZ_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int BOOT_FLUSH  = 2,
  parameter int MEM_TIMEOUT = 64,
  parameter int CW          = 10
) (
  input  wire logic     clk,
  input  wire logic     reset,
  hazard_ctrl_if.slave  hz
);

  localparam logic [1:0]    c_BOOT      = 2'd0;
  localparam logic [1:0]    c_RUN       = 2'd1;
  localparam logic [1:0]    c_WAIT      = 2'd2;
  localparam logic [1:0]    c_ERR       = 2'd3;
  localparam logic [3:0]    c_BOOT_LAST = 4'(BOOT_FLUSH - 1);
  localparam logic [CW-1:0] c_TIMEOUT   = CW'(MEM_TIMEOUT);

  logic [1:0]    r_state,    w_state_nxt;
  logic [3:0]    r_boot_cnt, w_boot_cnt_nxt;
  logic [CW-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic          r_mem_err,  w_mem_err_nxt;
  logic [CW-1:0] w_wait_inc;
  logic          w_lw_stall, w_mem_miss;
  logic          w_stall_f, w_stall_d, w_stall_e, w_stall_m;
  logic          w_flush_d, w_flush_e, w_flush_w;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs, input logic [4:0] rdm, input logic wm,
    input logic [4:0] rdw, input logic ww
  );
    if (wm && (rdm != 5'd0) && (rdm == rs))      return 2'b10;
    else if (ww && (rdw != 5'd0) && (rdw == rs)) return 2'b01;
    else                                         return 2'b00;
  endfunction

  assign w_lw_stall = hz.ResultSrcE0 && (hz.RdE != 5'd0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  assign w_mem_miss = hz.dmem_req && !hz.dmem_ready;
  assign w_wait_inc = r_wait_cnt + CW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= c_BOOT;
      r_boot_cnt <= '0;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_boot_cnt <= w_boot_cnt_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_mem_err  <= w_mem_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_boot_cnt_nxt = r_boot_cnt;
    w_wait_cnt_nxt = r_wait_cnt;
    w_mem_err_nxt  = r_mem_err;
    case (r_state)
      c_BOOT: begin
        w_boot_cnt_nxt = r_boot_cnt + 4'd1;
        if (r_boot_cnt == c_BOOT_LAST) w_state_nxt = c_RUN;
      end
      c_RUN: begin
        if (w_mem_miss) begin
          w_state_nxt    = c_WAIT;
          w_wait_cnt_nxt = CW'(1);
        end
      end
      c_WAIT: begin
        if (hz.dmem_ready) begin
          w_state_nxt    = c_RUN;
          w_wait_cnt_nxt = '0;
        end else begin
          w_wait_cnt_nxt = w_wait_inc;
          if (w_wait_inc == c_TIMEOUT) begin
            w_state_nxt   = c_ERR;
            w_mem_err_nxt = 1'b1;
          end
        end
      end
      c_ERR:   w_mem_err_nxt = 1'b1;
      default: w_state_nxt = c_BOOT;
    endcase
  end

  // A miss detected in RUN already presents the frozen-pipeline controls.
  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_stall_m = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    w_flush_w = 1'b0;
    case (r_state)
      c_BOOT: begin
        w_flush_d = 1'b1;
        w_flush_e = 1'b1;
      end
      c_RUN: begin
        if (w_mem_miss) begin
          {w_stall_f, w_stall_d, w_stall_e, w_stall_m, w_flush_w} = 5'b11111;
        end else begin
          w_stall_f = w_lw_stall;
          w_stall_d = w_lw_stall;
          w_flush_d = hz.PCSrcE;
          w_flush_e = w_lw_stall || hz.PCSrcE;
        end
      end
      c_WAIT, c_ERR: begin
        {w_stall_f, w_stall_d, w_stall_e, w_stall_m, w_flush_w} = 5'b11111;
      end
      default: ;
    endcase
  end

  assign hz.StallF    = w_stall_f;
  assign hz.StallD    = w_stall_d;
  assign hz.StallE    = w_stall_e;
  assign hz.StallM    = w_stall_m;
  assign hz.FlushD    = w_flush_d;
  assign hz.FlushE    = w_flush_e;
  assign hz.FlushW    = w_flush_w;
  assign hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
  assign hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
  assign hz.mem_err   = r_mem_err;

`ifdef HAZ_PERF_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_d) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_flush_e && (r_state != c_BOOT)) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign hz.stall_cnt = r_stall_cnt;
  assign hz.flush_cnt = r_flush_cnt;
`else
  assign hz.stall_cnt = 32'd0;
  assign hz.flush_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Directed vector bench for hazard_ctrl (BOOT_FLUSH=2, MEM_TIMEOUT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  hazard_ctrl_if bus ();

  hazard_ctrl #(
    .BOOT_FLUSH  (2),
    .MEM_TIMEOUT (4),
    .CW          (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,ForwardAE,ForwardBE}
  localparam logic [10:0] E_NONE = 11'b0000000_00_00;
  localparam logic [10:0] E_LU   = 11'b1100010_00_00;
  localparam logic [10:0] E_BR   = 11'b0000110_00_00;
  localparam logic [10:0] E_LUBR = 11'b1100110_00_00;
  localparam logic [10:0] E_WAIT = 11'b1111001_00_00;
  localparam logic [10:0] E_BOOT = 11'b0000110_00_00;

`ifdef HAZ_PERF_EN
  localparam logic [31:0] EXP_STALLS  = 32'd8;
  localparam logic [31:0] EXP_FLUSHES = 32'd6;
`else
  localparam logic [31:0] EXP_STALLS  = 32'd0;
  localparam logic [31:0] EXP_FLUSHES = 32'd0;
`endif

  typedef struct {
    string      name;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       wm, ww, ld, br, req, rdy;
    logic [10:0] exp;
  } vec_t;

  vec_t vt [13];

  function automatic vec_t mk(
    input string n, input int rs1d, input int rs2d, input int rs1e, input int rs2e,
    input int rde, input int rdm, input int rdw, input bit wm, input bit ww,
    input bit ld, input bit br, input bit req, input bit rdy, input logic [10:0] exp
  );
    vec_t v;
    v.name = n;
    v.rs1d = 5'(rs1d); v.rs2d = 5'(rs2d); v.rs1e = 5'(rs1e); v.rs2e = 5'(rs2e);
    v.rde = 5'(rde); v.rdm = 5'(rdm); v.rdw = 5'(rdw);
    v.wm = wm; v.ww = ww; v.ld = ld; v.br = br; v.req = req; v.rdy = rdy;
    v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.Rs1D = v.rs1d; bus.Rs2D = v.rs2d; bus.Rs1E = v.rs1e; bus.Rs2E = v.rs2e;
    bus.RdE = v.rde; bus.RdM = v.rdm; bus.RdW = v.rdw;
    bus.RegWriteM = v.wm; bus.RegWriteW = v.ww; bus.ResultSrcE0 = v.ld;
    bus.PCSrcE = v.br; bus.dmem_req = v.req; bus.dmem_ready = v.rdy;
  endtask

  task automatic clear_inputs();
    drive(mk("clr", 0,0,0,0,0,0,0, 0,0,0,0,0,0, E_NONE));
  endtask

  task automatic chk_ctrl(input string name, input logic [10:0] exp);
    logic [10:0] act;
    act = {bus.StallF, bus.StallD, bus.StallE, bus.StallM, bus.FlushD, bus.FlushE,
           bus.FlushW, bus.ForwardAE, bus.ForwardBE};
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: ctrl got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // One clock cycle with the current inputs: check mid-cycle, then advance.
  task automatic cyc(input string name, input logic [10:0] exp, input logic exp_err);
    @(negedge clk);
    chk_ctrl(name, exp);
    chk_val({name, ".mem_err"}, {31'd0, bus.mem_err}, {31'd0, exp_err});
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0]  = mk("idle",     0,0,0,0,0,0,0, 0,0,0,0,0,0, E_NONE);
    vt[1]  = mk("lu_rs1",   5,0,0,0,5,0,0, 0,0,1,0,0,0, E_LU);
    vt[2]  = mk("lu_x0",    0,0,0,0,0,0,0, 0,0,1,0,0,0, E_NONE);
    vt[3]  = mk("lu_rs2",   3,9,0,0,9,0,0, 0,0,1,0,0,0, E_LU);
    vt[4]  = mk("noload",   5,0,0,0,5,0,0, 0,0,0,0,0,0, E_NONE);
    vt[5]  = mk("fwd_mem",  0,0,7,0,0,7,7, 1,1,0,0,0,0, 11'b0000000_10_00);
    vt[6]  = mk("fwd_wb",   0,0,7,0,0,7,7, 0,1,0,0,0,0, 11'b0000000_01_00);
    vt[7]  = mk("fwd_none", 0,0,0,7,0,7,7, 0,0,0,0,0,0, E_NONE);
    vt[8]  = mk("fwd_x0",   0,0,0,0,0,0,0, 1,1,0,0,0,0, E_NONE);
    vt[9]  = mk("fwd_mix",  0,0,4,3,0,3,4, 1,1,0,0,0,0, 11'b0000000_01_10);
    vt[10] = mk("branch",   0,0,0,0,0,0,0, 0,0,0,1,0,0, E_BR);
    vt[11] = mk("lu_br",    5,0,0,0,5,0,0, 0,0,1,1,0,0, E_LUBR);
    vt[12] = mk("req_hit",  0,0,0,0,0,0,0, 0,0,0,0,1,1, E_NONE);

    reset = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_ctrl("in_reset", E_BOOT);
    chk_val("in_reset.mem_err", {31'd0, bus.mem_err}, 32'd0);
    chk_val("in_reset.stall_cnt", bus.stall_cnt, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc("boot1", E_BOOT, 1'b0);
    cyc("boot2", E_BOOT, 1'b0);
    cyc("run0",  E_NONE, 1'b0);

    for (int i = 0; i < 13; i++) begin
      drive(vt[i]);
      cyc(vt[i].name, vt[i].exp, 1'b0);
    end

    drive(vt[11]);
    cyc("lubr_hand", E_LUBR, 1'b0);
    clear_inputs();
    cyc("lubr_next", E_NONE, 1'b0);

    // Miss with a branch pending in EX: branch must wait for the memory.
    bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0; bus.PCSrcE = 1'b1;
    cyc("wait_a", E_WAIT, 1'b0);
    bus.ResultSrcE0 = 1'b1; bus.RdE = 5'd5; bus.Rs1D = 5'd5;
    cyc("wait_b", E_WAIT, 1'b0);
    bus.ResultSrcE0 = 1'b0; bus.RdE = 5'd0; bus.Rs1D = 5'd0;
    cyc("wait_c", E_WAIT, 1'b0);
    bus.dmem_ready = 1'b1;
    cyc("wait_d", E_WAIT, 1'b0);
    bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
    cyc("wait_br", E_BR, 1'b0);
    clear_inputs();
    @(negedge clk);
    chk_ctrl("post_wait", E_NONE);
    chk_val("stall_cnt", bus.stall_cnt, EXP_STALLS);
    chk_val("flush_cnt", bus.flush_cnt, EXP_FLUSHES);
    @(posedge clk);
    #1;

    bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
    cyc("to1", E_WAIT, 1'b0);
    cyc("to2", E_WAIT, 1'b0);
    cyc("to3", E_WAIT, 1'b0);
    cyc("to4", E_WAIT, 1'b0);
    cyc("err1", E_WAIT, 1'b1);
    bus.dmem_req = 1'b0; bus.dmem_ready = 1'b1; bus.PCSrcE = 1'b1;
    cyc("err2", E_WAIT, 1'b1);
    cyc("err3", E_WAIT, 1'b1);

    clear_inputs();
    reset = 1'b0;
    #1;
    chk_ctrl("err_reset", E_BOOT);
    chk_val("err_reset.mem_err", {31'd0, bus.mem_err}, 32'd0);
    chk_val("err_reset.stall_cnt", bus.stall_cnt, 32'd0);
    chk_val("err_reset.flush_cnt", bus.flush_cnt, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc("reboot1", E_BOOT, 1'b0);
    cyc("reboot2", E_BOOT, 1'b0);
    cyc("rerun",   E_NONE, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
